// File: rtl/score4_move_ctrl.sv
// score4 move sequencer: cursor motion, token writes, win-check handshake.
// Define SCORE4_CURSOR_WRAP_EN to let the cursor wrap around the panel edges.
module score4_move_ctrl #(
    parameter int COLS      = 7,
    parameter int ROWS      = 6,
    parameter int START_COL = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       left,
    input  logic       right,
    input  logic       put,
    output logic [2:0] cursor_col,
    output logic       player,
    output logic       invalid_move,
    output logic       wr_en,
    output logic [2:0] wr_row,
    output logic [2:0] wr_col,
    output logic       wr_player,
    output logic       chk_start,
    output logic [2:0] chk_row,
    output logic [2:0] chk_col,
    input  logic       chk_done,
    input  logic       chk_win,
    output logic       win_a,
    output logic       win_b,
    output logic       full_panel
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int HW = $clog2(ROWS + 1);
    localparam int MW = $clog2(COLS * ROWS + 1);
    localparam int NC = 1 << CW;

    typedef enum logic [1:0] {IDLE, WRITE, CHECK, OVER} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cur_q, cur_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [HW-1:0] height_q [NC];
    logic [HW-1:0] height_d [NC];
    logic [MW-1:0] moves_q, moves_d;
    logic          player_q, player_d;
    logic          inv_q, inv_d;
    logic          wr_en_q, wr_en_d;
    logic          chk_start_q, chk_start_d;
    logic          win_a_q, win_a_d;
    logic          win_b_q, win_b_d;
    logic          full_q, full_d;
    logic          col_full;

    assign col_full = (height_q[cur_q] == HW'(ROWS));

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        col_d       = col_q;
        row_d       = row_q;
        height_d    = height_q;
        moves_d     = moves_q;
        player_d    = player_q;
        inv_d       = inv_q;
        wr_en_d     = 1'b0;
        chk_start_d = 1'b0;
        win_a_d     = win_a_q;
        win_b_d     = win_b_q;
        full_d      = full_q;
        unique case (state_q)
            IDLE: begin
                if (put) begin
                    if (col_full) begin
                        inv_d = 1'b1;
                    end else begin
                        inv_d   = 1'b0;
                        row_d   = RW'(height_q[cur_q]);
                        col_d   = cur_q;
                        wr_en_d = 1'b1;
                        state_d = WRITE;
                    end
                end else if (right) begin
                    if (cur_q == CW'(COLS - 1)) begin
`ifdef SCORE4_CURSOR_WRAP_EN
                        cur_d = '0;
                        inv_d = 1'b0;
`else
                        inv_d = 1'b1;
`endif
                    end else begin
                        cur_d = cur_q + CW'(1);
                        inv_d = 1'b0;
                    end
                end else if (left) begin
                    if (cur_q == '0) begin
`ifdef SCORE4_CURSOR_WRAP_EN
                        cur_d = CW'(COLS - 1);
                        inv_d = 1'b0;
`else
                        inv_d = 1'b1;
`endif
                    end else begin
                        cur_d = cur_q - CW'(1);
                        inv_d = 1'b0;
                    end
                end
            end
            WRITE: begin
                height_d[col_q] = height_q[col_q] + HW'(1);
                moves_d         = moves_q + MW'(1);
                chk_start_d     = 1'b1;
                state_d         = CHECK;
            end
            CHECK: begin
                // moves_q already counts the token under evaluation
                if (chk_done) begin
                    if (chk_win) begin
                        win_a_d = ~player_q;
                        win_b_d = player_q;
                        state_d = OVER;
                    end else if (moves_q == MW'(COLS * ROWS)) begin
                        full_d  = 1'b1;
                        state_d = OVER;
                    end else begin
                        player_d = ~player_q;
                        state_d  = IDLE;
                    end
                end
            end
            OVER: begin
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_q       <= CW'(START_COL);
            col_q       <= '0;
            row_q       <= '0;
            height_q    <= '{default: '0};
            moves_q     <= '0;
            player_q    <= 1'b0;
            inv_q       <= 1'b0;
            wr_en_q     <= 1'b0;
            chk_start_q <= 1'b0;
            win_a_q     <= 1'b0;
            win_b_q     <= 1'b0;
            full_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            col_q       <= col_d;
            row_q       <= row_d;
            height_q    <= height_d;
            moves_q     <= moves_d;
            player_q    <= player_d;
            inv_q       <= inv_d;
            wr_en_q     <= wr_en_d;
            chk_start_q <= chk_start_d;
            win_a_q     <= win_a_d;
            win_b_q     <= win_b_d;
            full_q      <= full_d;
        end
    end

    assign cursor_col   = 3'(cur_q);
    assign player       = player_q;
    assign invalid_move = inv_q;
    assign wr_en        = wr_en_q;
    assign wr_row       = 3'(row_q);
    assign wr_col       = 3'(col_q);
    assign wr_player    = player_q;
    assign chk_start    = chk_start_q;
    assign chk_row      = 3'(row_q);
    assign chk_col      = 3'(col_q);
    assign win_a        = win_a_q;
    assign win_b        = win_b_q;
    assign full_panel   = full_q;

endmodule

// File: tb/tb_score4_move_ctrl.sv
// Self-checking bench for score4_move_ctrl: vector table, corner sequences
// and randomized commands against a game-level reference model.
module tb_score4_move_ctrl;
    localparam int COLS      = 7;
    localparam int ROWS      = 6;
    localparam int START_COL = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       left = 1'b0, right = 1'b0, put = 1'b0;
    logic       chk_done = 1'b0, chk_win = 1'b0;
    logic [2:0] cursor_col, wr_row, wr_col, chk_row, chk_col;
    logic       player, invalid_move, wr_en, wr_player, chk_start;
    logic       win_a, win_b, full_panel;

    int total = 0;
    int bad   = 0;

    score4_move_ctrl #(.COLS(COLS), .ROWS(ROWS), .START_COL(START_COL)) dut (
        .clk(clk), .rst(rst), .left(left), .right(right), .put(put),
        .cursor_col(cursor_col), .player(player), .invalid_move(invalid_move),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_player(wr_player),
        .chk_start(chk_start), .chk_row(chk_row), .chk_col(chk_col),
        .chk_done(chk_done), .chk_win(chk_win),
        .win_a(win_a), .win_b(win_b), .full_panel(full_panel)
    );

    always #10 clk = ~clk;

    // game-level model: cursor, column heights, whose turn, token in flight
    int m_cur, m_pl, m_inv, m_moves, m_since, m_row, m_col;
    int m_h [COLS];
    bit m_wr, m_cs, m_wa, m_wb, m_full, m_over;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [22:0] act_vec();
        return {cursor_col, player, invalid_move, wr_en, wr_row, wr_col,
                wr_player, chk_start, chk_row, chk_col,
                win_a, win_b, full_panel};
    endfunction

    task automatic model_reset();
        m_cur = START_COL; m_pl = 0; m_inv = 0; m_moves = 0; m_since = 0;
        m_row = 0; m_col = 0;
        m_wr = 0; m_cs = 0; m_wa = 0; m_wb = 0; m_full = 0; m_over = 0;
        for (int c = 0; c < COLS; c++) m_h[c] = 0;
    endtask

    task automatic model_edge(input bit l, r, p, d, w);
        m_wr = 0;
        m_cs = 0;
        if (m_over) begin
        end else if (m_since == 0) begin
            if (p) begin
                if (m_h[m_cur] == ROWS) m_inv = 1;
                else begin
                    m_inv = 0; m_row = m_h[m_cur]; m_col = m_cur;
                    m_since = 1; m_wr = 1;
                end
            end else if (r) begin
`ifdef SCORE4_CURSOR_WRAP_EN
                m_cur = (m_cur + 1) % COLS; m_inv = 0;
`else
                if (m_cur == COLS - 1) m_inv = 1;
                else begin m_cur++; m_inv = 0; end
`endif
            end else if (l) begin
`ifdef SCORE4_CURSOR_WRAP_EN
                m_cur = (m_cur + COLS - 1) % COLS; m_inv = 0;
`else
                if (m_cur == 0) m_inv = 1;
                else begin m_cur--; m_inv = 0; end
`endif
            end
        end else if (m_since == 1) begin
            m_h[m_col]++; m_moves++; m_since = 2; m_cs = 1;
        end else if (d) begin
            m_since = 0;
            if (w) begin
                if (m_pl == 1) m_wb = 1; else m_wa = 1;
                m_over = 1;
            end else if (m_moves == COLS * ROWS) begin
                m_full = 1; m_over = 1;
            end else m_pl ^= 1;
        end
    endtask

    task automatic model_compare();
        logic [22:0] e, mask;
        e = {3'(m_cur), 1'(m_pl), 1'(m_inv), m_wr, 3'(m_row), 3'(m_col),
             1'(m_pl), m_cs, 3'(m_row), 3'(m_col), m_wa, m_wb, m_full};
        mask = '1;
        if (!m_wr) mask[13:7] = '0;
        if (m_since < 2) mask[8:3] = '0;
        check("model", 32'(act_vec() & mask), 32'(e & mask));
    endtask

    task automatic step(input bit l, r, p, d, w);
        left = l; right = r; put = p; chk_done = d; chk_win = w;
        @(posedge clk);
        model_edge(l, r, p, d, w);
        #1;
        left = 0; right = 0; put = 0; chk_done = 0; chk_win = 0;
        model_compare();
    endtask

    task automatic do_reset();
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        check("reset", 32'(act_vec()), 32'({3'(START_COL), 20'b0}));
    endtask

    task automatic place(input bit win);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, win);
    endtask

    typedef struct {
        bit l, r, p, d, w;
        logic [2:0] cur;
        logic pl, inv, wr, cs;
    } vec_t;

    vec_t tbl [9];

    initial begin
`ifdef SCORE4_CURSOR_WRAP_EN
        tbl[0] = '{1, 0, 0, 0, 0, 3'(COLS - 1), 0, 0, 0, 0};
        tbl[1] = '{0, 1, 0, 0, 0, 3'd0, 0, 0, 0, 0};
        tbl[2] = '{0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0};
`else
        tbl[0] = '{1, 0, 0, 0, 0, 3'd0, 0, 1, 0, 0};
        tbl[1] = '{0, 1, 0, 0, 0, 3'd1, 0, 0, 0, 0};
        tbl[2] = '{1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0};
`endif
        tbl[3] = '{1, 1, 1, 0, 0, 3'd0, 0, 0, 1, 0};
        tbl[4] = '{0, 0, 1, 0, 0, 3'd0, 0, 0, 0, 1};
        tbl[5] = '{0, 1, 0, 0, 0, 3'd0, 0, 0, 0, 0};
        tbl[6] = '{0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0};
        tbl[7] = '{0, 0, 0, 1, 0, 3'd0, 1, 0, 0, 0};
        tbl[8] = '{0, 0, 0, 0, 0, 3'd0, 1, 0, 0, 0};

        model_reset();
        #3;
        check("async_reset", 32'(act_vec()), 32'({3'(START_COL), 20'b0}));
        do_reset();

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].l, tbl[i].r, tbl[i].p, tbl[i].d, tbl[i].w);
            check($sformatf("tbl%0d", i),
                  32'({cursor_col, player, invalid_move, wr_en, chk_start}),
                  32'({tbl[i].cur, tbl[i].pl, tbl[i].inv, tbl[i].wr, tbl[i].cs}));
        end
        check("tbl_wr_pos", 32'({wr_row, wr_col}), 32'(0));

        // seven puts into column 3
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        for (int i = 0; i < ROWS; i++) begin
            step(0, 0, 1, 0, 0);
            check("col_wr", 32'({wr_en, wr_row, wr_col, wr_player}),
                  32'({1'b1, 3'(i), 3'd3, 1'(i % 2)}));
            step(0, 0, 0, 0, 0);
            check("col_chk", 32'({chk_start, chk_row, chk_col}),
                  32'({1'b1, 3'(i), 3'd3}));
            step(0, 0, 0, 1, 0);
            check("col_player", 32'(player), 32'((i + 1) % 2));
        end
        step(0, 0, 1, 0, 0);
        check("col_full_put", 32'({invalid_move, wr_en, player}), 32'(3'b100));
        step(0, 0, 0, 0, 0);
        check("col_full_idle", 32'({wr_en, chk_start}), 32'(0));

        // vertical win for A in column 0
        do_reset();
        for (int k = 0; k < 3; k++) begin
            place(0);
            step(0, 1, 0, 0, 0);
            place(0);
            step(1, 0, 0, 0, 0);
        end
        place(1);
        check("win_a", 32'({win_a, win_b, full_panel, player}), 32'(4'b1000));
        step(0, 0, 1, 0, 0);
        check("over_put", 32'(wr_en), 32'(0));
        step(0, 0, 0, 1, 1);
        check("over_hold", 32'({win_a, win_b, chk_start}), 32'(3'b100));

        // fill the whole panel with no win
        do_reset();
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                place(0);
                if (c * ROWS + r == COLS * ROWS - 2)
                    check("full_early", 32'(full_panel), 32'(0));
            end
            if (c < COLS - 1) step(0, 1, 0, 0, 0);
        end
        check("full", 32'({full_panel, win_a, win_b}), 32'(3'b100));
        step(0, 0, 1, 0, 0);
        check("full_put", 32'(wr_en), 32'(0));

        // put while busy, then asynchronous reset mid-CHECK
        do_reset();
        place(0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        check("busy_put", 32'({wr_en, invalid_move}), 32'(0));
        #2;
        rst = 1;
        #1;
        check("mid_reset", 32'(act_vec()), 32'({3'(START_COL), 20'b0}));
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        step(0, 0, 1, 0, 0);
        check("height_clr", 32'({wr_en, wr_row, wr_col, wr_player}),
              32'({1'b1, 3'd0, 3'd0, 1'b0}));

        // randomized play against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ((m_over && $urandom_range(0, 3) == 0) ||
                $urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 3) == 0,
                     (m_since >= 2) ? ($urandom_range(0, 2) == 0)
                                    : ($urandom_range(0, 9) == 0),
                     $urandom_range(0, 24) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/score4_move_ctrl.md
Name: score4_move_ctrl

Overview:
Move sequencer for the score4 game core.
- Converts the single-cycle left/right/put commands into cursor motion and token writes to the panel store.
- Tracks per-column fill heights, the current player and the move count.
- Hands each placed token to the win-checker over a start/done handshake, then resolves win, full-panel or player change.
- Sits between the input front-end and the panel memory / win-check / VGA renderer.

Parameters:
COLS, 7, number of panel columns (2..8)
ROWS, 6, number of panel rows (2..8)
START_COL, 0, cursor column after reset (0..COLS-1)

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous, active-high reset
left  in  1  move cursor one column left; single-cycle pulse
right  in  1  move cursor one column right; single-cycle pulse
put  in  1  drop a token in the cursor column; single-cycle pulse
cursor_col  out  3  current cursor column
player  out  1  player to move: 0 = A, 1 = B
invalid_move  out  1  last accepted command was illegal
wr_en  out  1  one-cycle panel write strobe
wr_row  out  3  row written, 0 = bottom
wr_col  out  3  column written
wr_player  out  1  owner of the written token
chk_start  out  1  one-cycle pulse: evaluate the token just written
chk_row  out  3  row of the token to evaluate
chk_col  out  3  column of the token to evaluate
chk_done  in  1  win-checker finished; single-cycle pulse
chk_win  in  1  valid with chk_done: four-in-line through (chk_row, chk_col)
win_a  out  1  player A has won; sticky
win_b  out  1  player B has won; sticky
full_panel  out  1  COLS*ROWS tokens placed, no win; sticky

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high; all state clears immediately on assertion, including mid-WRITE or mid-CHECK.
- Reset values:
  - cursor_col = START_COL.
  - player, invalid_move, wr_en, chk_start, win_a, win_b, full_panel = 0.
  - wr_row/wr_col/wr_player/chk_row/chk_col = 0.
  - All column heights = 0; move count = 0; state = IDLE.
- States: IDLE, WRITE, CHECK, OVER.
- IDLE: one command is sampled per cycle. Priority is put > right > left when several are high together; the losers are dropped.
  - left: if cursor_col == 0, set invalid_move=1 and leave the cursor; else cursor_col-1 and invalid_move=0. Registered; visible next cycle.
  - right: if cursor_col == COLS-1, set invalid_move=1; else cursor_col+1 and invalid_move=0.
  - put, column full (height[cursor] == ROWS): invalid_move=1, stay IDLE, no write.
  - put, otherwise: invalid_move=0. Latch row = height[cursor] and col = cursor_col, then go to WRITE.
- WRITE (exactly 1 cycle):
  - wr_en=1, wr_row=latched row, wr_col=latched col, wr_player=player.
  - height[col]++ and move count++.
  - Next state CHECK.
- CHECK:
  - chk_start pulses for exactly the first CHECK cycle. chk_row/chk_col hold the latched position throughout CHECK.
  - Wait for chk_done; there is no timeout. chk_done arriving in the same cycle as chk_start is legal.
  - On chk_done with chk_win=1: set win_a if player==0, else win_b; go to OVER. player is not toggled.
  - On chk_done with chk_win=0 and move count == COLS*ROWS: set full_panel=1; go to OVER.
  - On chk_done otherwise: toggle player; return to IDLE.
- Busy rule: left/right/put arriving in WRITE or CHECK are ignored and are not queued. invalid_move is unchanged by them.
- Latency: put sampled at edge N gives wr_en high in cycle N+1 and chk_start high in cycle N+2. The earliest next accepted command is 1 cycle after chk_done.
- OVER: all commands ignored. All outputs hold until rst. win_a, win_b and full_panel are mutually exclusive.
- Widths: height counters are $clog2(ROWS+1) bits; move count is $clog2(COLS*ROWS+1) bits. Row and column outputs are zero-extended to 3 bits.
- chk_done while IDLE or OVER is ignored.

Optional Feature:
Macro: SCORE4_CURSOR_WRAP_EN
- Defined:
  - left at column 0 moves the cursor to COLS-1; right at COLS-1 moves it to 0.
  - Both set invalid_move=0; edge moves are never invalid.
- Undefined: edge moves are invalid and the cursor holds, as in Behaviour.
- Put and full-column handling are identical in both builds.

Test Plan:
- Reset, then left at column 0 -> cursor_col stays 0 and invalid_move=1. A following right -> cursor_col=1 and invalid_move=0.
- Put at column 0; checker model returns chk_done with chk_win=0 after 3 cycles -> wr_en one cycle later with row 0, col 0, player 0; chk_start the cycle after; player=1 after chk_done.
- Seven puts in column 3, checker never reports a win -> six writes to rows 0..5. The 7th put gives invalid_move=1, no wr_en, and player unchanged by it.
- Column win for A: put/right/put/left repeated 3 times then put, checker asserts chk_win on the 7th token -> win_a=1, win_b=0, player=0. Later puts produce no wr_en.
- Fill all 42 cells with no win reported -> full_panel=1 exactly after the 42nd chk_done; the 43rd put is ignored.
- Put pulse during CHECK -> no extra write. Assert rst mid-CHECK -> all outputs back to reset values asynchronously and heights cleared.
